cpu_sequencer: RTL
==================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 5, stages per instruction; SHALL be at least 2.
REQ-002 Parameter PC_WIDTH, default 32, program counter width in bits.
REQ-003 Parameter PC_STEP, default 1, sequential PC increment.
REQ-004 Parameter RESET_PC, default 0, PC value after reset.
REQ-005 Parameter SW, default $clog2(NUM_STAGES), stage index width.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst  input  1  asynchronous reset, active-low; clears all state immediately while low.
REQ-008 mem_need  input  NUM_STAGES  per-stage mask; bit s high means stage s of the current instruction needs memory (bit 0 ignored, always treated as high).
REQ-009 mem_ack  input  1  memory completion for the outstanding request.
REQ-010 branch_taken  input  1  sampled only in the last stage.
REQ-011 branch_target  input  PC_WIDTH  next PC when branch_taken.
REQ-012 halt_req  input  1  sampled only in the last stage.
REQ-013 stage  output  SW  current stage index.
REQ-014 fetch_en  output  1  high in stage 0 on the mem_ack cycle; instruction-register load strobe.
REQ-015 pc_update_en  output  1  high in every last-stage cycle in RUN.
REQ-016 mem_req  output  1  memory request.
REQ-017 pc  output  PC_WIDTH  current program counter.
REQ-018 stall  output  1  high when mem_req is high and mem_ack is low.
REQ-019 halted  output  1  sequencer is in HALT.

Function
REQ-020 The FSM SHALL have two states, RUN and HALT; stage is meaningful only in RUN.
REQ-021 In RUN, mem_req SHALL be high exactly when mem_need[stage] is high, or stage is 0.
REQ-022 Stage advance in RUN:
- If mem_req is high and mem_ack is low, stage SHALL hold.
- Otherwise stage SHALL advance by 1 per cycle.
- From stage NUM_STAGES-1 it SHALL wrap to 0 after one cycle.
REQ-023 mem_ack SHALL be ignored whenever mem_req is low.
REQ-024 In the last stage, pc SHALL load branch_target if branch_taken, else pc+PC_STEP, modulo 2^PC_WIDTH (wrap with no flag).
REQ-025 If halt_req is high in the last stage:
- the PC update SHALL still occur;
- the FSM SHALL enter HALT with stage=0 on the next cycle.
REQ-026 HALT SHALL be left only by reset; in HALT, mem_req, fetch_en and pc_update_en SHALL be 0 and pc SHALL hold.
REQ-027 Latency with no stalls SHALL be exactly NUM_STAGES cycles per instruction; each stall cycle adds exactly one cycle.
REQ-028 When halt_req and branch_taken are both high, the branch target SHALL be taken before halting.
REQ-029 mem_need changing during a stalled stage SHALL take effect combinationally on mem_req.

Reset
REQ-030 While rst is low, outputs SHALL be: stage=0, pc=RESET_PC, halted=0, mem_req=1, fetch_en=0, pc_update_en=0, stall=1.
REQ-031 Reset asserted mid-instruction or mid-stall SHALL abandon the instruction with no PC update.
REQ-032 Reset deassertion SHALL be synchronised by the integrator; the first edge after release SHALL be the first RUN cycle in stage 0.

Configuration
REQ-033 Macro SEQ_WATCHDOG_EN selects a memory-wait watchdog.
- Defined: an 8-bit counter counts consecutive stall cycles and clears on any non-stall cycle.
- Defined: when the counter reaches 255, the FSM SHALL enter HALT and raise output watchdog_err (1 bit), which is held until reset; reset value 0.
- Undefined: no counter and no watchdog_err port; a stall MAY last indefinitely.

Verification
REQ-034 NUM_STAGES=5, mem_ack tied 1, mem_need=0 -> stage sequence 0,1,2,3,4,0; pc goes 0,1,2 at 5-cycle intervals; fetch_en once per instruction.
REQ-035 mem_ack low for 3 cycles in stage 0 -> stage holds 0 for 4 cycles with stall=1 for 3 of them; pc update delayed by exactly 3 cycles.
REQ-036 branch_taken=1, branch_target=0x40 at stage 4 -> pc=0x40 next cycle; PC_WIDTH=4, pc=0xF, no branch -> pc=0x0.
REQ-037 halt_req=1 with branch_taken=1, target 0x10, at stage 4 -> pc=0x10, halted=1, mem_req=0 from then on until rst low.
REQ-038 rst pulled low during a stall in stage 2 with pc=7 -> immediately stage=0, pc=RESET_PC, halted=0.
REQ-039 With SEQ_WATCHDOG_EN, mem_ack held 0 -> watchdog_err=1 and halted=1 after 255 stall cycles; a single ack before that clears the count.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - sequencer control/memory handshake bundle; carries watchdog_err when SEQ_WATCHDOG_EN is defined
interface cpu_sequencer_if #(
   parameter int NUM_STAGES = 5,
   parameter int PC_WIDTH   = 32,
   parameter int SW         = $clog2(NUM_STAGES)
);
   logic [NUM_STAGES-1:0] mem_need;
   logic                  mem_ack;
   logic                  branch_taken;
   logic [PC_WIDTH-1:0]   branch_target;
   logic                  halt_req;
   logic [SW-1:0]         stage;
   logic                  fetch_en;
   logic                  pc_update_en;
   logic                  mem_req;
   logic [PC_WIDTH-1:0]   pc;
   logic                  stall;
   logic                  halted;
`ifdef SEQ_WATCHDOG_EN
   logic                  watchdog_err;
`endif

   modport master (
      input  mem_need, mem_ack, branch_taken, branch_target, halt_req,
      output stage, fetch_en, pc_update_en, mem_req, pc, stall, halted
`ifdef SEQ_WATCHDOG_EN
      , output watchdog_err
`endif
   );

   modport slave (
      output mem_need, mem_ack, branch_taken, branch_target, halt_req,
      input  stage, fetch_en, pc_update_en, mem_req, pc, stall, halted
`ifdef SEQ_WATCHDOG_EN
      , input watchdog_err
`endif
   );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle instruction stage sequencer with RUN/HALT FSM
// Optional memory-wait watchdog enabled by defining SEQ_WATCHDOG_EN.
module cpu_sequencer #(
   parameter int NUM_STAGES = 5,
   parameter int PC_WIDTH   = 32,
   parameter int PC_STEP    = 1,
   parameter int RESET_PC   = 0,
   parameter int SW         = $clog2(NUM_STAGES)
) (
   input  logic            clk,
   input  logic            rst,
   cpu_sequencer_if.master bus
);
   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

   state_t              state_q, state_d;
   logic [SW-1:0]       stage_q, stage_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                run;
   logic                is_last;
   logic                mem_req_c;
   logic                wait_c;

   assign run       = (state_q == RUN);
   assign is_last   = (stage_q == LAST_STAGE);
   assign mem_req_c = run && ((stage_q == '0) || bus.mem_need[stage_q]);
   assign wait_c    = mem_req_c && !bus.mem_ack;

   assign bus.stage        = stage_q;
   assign bus.pc           = pc_q;
   assign bus.halted       = !run;
   assign bus.mem_req      = mem_req_c;
   // Reset drives stall high regardless of whatever mem_ack happens to be
   assign bus.stall        = !rst || wait_c;
   assign bus.fetch_en     = rst && run && (stage_q == '0) && bus.mem_ack;
   assign bus.pc_update_en = rst && run && is_last && !wait_c;

`ifdef SEQ_WATCHDOG_EN
   logic [7:0] wd_q, wd_d;
   logic       wd_err_q, wd_err_d;

   assign bus.watchdog_err = wd_err_q;
`endif

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      pc_d    = pc_q;
`ifdef SEQ_WATCHDOG_EN
      wd_d     = wait_c ? wd_q + 8'd1 : 8'd0;
      wd_err_d = wd_err_q;
`endif
      if (run && !wait_c) begin
         if (is_last) begin
            stage_d = '0;
            pc_d    = bus.branch_taken ? bus.branch_target : pc_q + PC_WIDTH'(PC_STEP);
            if (bus.halt_req) begin
               state_d = HALT;
            end
         end else begin
            stage_d = stage_q + SW'(1);
         end
      end
`ifdef SEQ_WATCHDOG_EN
      // The 255th consecutive stall cycle trips the watchdog
      if (wait_c && (wd_q == 8'd254)) begin
         state_d  = HALT;
         stage_d  = '0;
         wd_err_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         stage_q  <= '0;
         pc_q     <= PC_WIDTH'(RESET_PC);
`ifdef SEQ_WATCHDOG_EN
         wd_q     <= 8'd0;
         wd_err_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         pc_q     <= pc_d;
`ifdef SEQ_WATCHDOG_EN
         wd_q     <= wd_d;
         wd_err_q <= wd_err_d;
`endif
      end
   end
endmodule
